// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES state serializer path.
package aes_pkg;
  localparam int NROWS  = 4;
  localparam int DEF_NB = 4;

  typedef logic [7:0] byte_t;
  typedef byte_t state_t [NROWS][DEF_NB];

  function automatic int beats(input int nb, input int out_w);
    return (32 * nb) / out_w;
  endfunction
endpackage

// File: rtl/state_pack.sv
// Combinational packer: 4xNB byte matrix -> PW-bit word, column- or row-major.
module state_pack
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [7:0]        matrix [NROWS][NB],
  input  logic              row_major,
  output logic [32*NB-1:0]  word
);

  // Byte k lands at bits [8k+7:8k]; matrix[3][NB-1] is always the top byte.
  always_comb begin
    word = '0;
    for (int r = 0; r < NROWS; r++) begin
      for (int c = 0; c < NB; c++) begin
        if (row_major) word[8*(NB*r+c) +: 8]    = matrix[r][c];
        else           word[8*(NROWS*c+r) +: 8] = matrix[r][c];
      end
    end
  end

endmodule

// File: rtl/state_serializer.sv
// Captures one 4xNB state matrix and streams it out as OUT_W-bit beats, MSB beat first.
// First beat one cycle after capture; beats held under backpressure; reload on last beat.
module state_serializer
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_matrix [NROWS][NB],
  input  logic              in_row_major,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last
);

  localparam int PW    = 32 * NB;
  localparam int BEATS = beats(NB, OUT_W);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  if ((PW % OUT_W) != 0 || OUT_W < 8) begin : g_bad_width
    $error("state_serializer: OUT_W must divide 32*NB and be at least 8");
  end

  typedef enum logic {S_IDLE, S_SEND} fsm_t;

  fsm_t            state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   sreg;
  logic [PW-1:0]   packed_word;
  logic            last_q;

  state_pack #(.NB(NB)) u_pack (
    .matrix    (in_matrix),
    .row_major (in_row_major),
    .word      (packed_word)
  );

  assign out_data = sreg[PW-1 -: OUT_W];
  assign out_last = last_q;
  // A new matrix is only taken when idle or as the last beat leaves.
  assign in_ready = (state == S_IDLE) || (out_ready && last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sreg      <= '0;
      out_valid <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state     <= S_SEND;
            sreg      <= packed_word;
            cnt       <= '0;
            out_valid <= 1'b1;
            last_q    <= (BEATS == 1);
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (last_q) begin
              if (in_valid) begin
                sreg   <= packed_word;
                cnt    <= '0;
                last_q <= (BEATS == 1);
              end else begin
                state     <= S_IDLE;
                sreg      <= '0;
                cnt       <= '0;
                out_valid <= 1'b0;
                last_q    <= 1'b0;
              end
            end else begin
              sreg   <= sreg << OUT_W;
              cnt    <= cnt + 1'b1;
              last_q <= ((cnt + 1'b1) == LAST_CNT);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
